// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers the execute bus, holds SRAM load data across
// writeback stalls, forms the GPR write value. Optional sub-word loads: MS_LOAD_EXT_EN.
module mem_stage #(
`ifdef MS_LOAD_EXT_EN
  parameter int ES_TO_MS_BUS_WD = 75,
`else
  parameter int ES_TO_MS_BUS_WD = 72,
`endif
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [38:0]                ms_fwd_bus
);

  localparam logic MS_READY_GO = 1'b1;

  logic                       ms_valid_q, ms_valid_d;
  logic                       buf_valid_q, buf_valid_d;
  logic                       first_q, first_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic [31:0]                rdata_buf_q, rdata_buf_d;

  logic        load_op;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] rdata_sel;
  logic [31:0] load_data;
  logic [31:0] final_result;

  assign load_op    = bus_q[70];
  assign gr_we      = bus_q[69];
  assign dest       = bus_q[68:64];
  assign alu_result = bus_q[63:32];
  assign pc         = bus_q[31:0];

  // store_op only matters upstream: decode already forces gr_we low for stores
  logic unused_store_op;
  assign unused_store_op = bus_q[71];

  assign ms_allowin     = !ms_valid_q || (MS_READY_GO && ws_allowin);
  assign ms_to_ws_valid = ms_valid_q && MS_READY_GO;

  always_comb begin
    ms_valid_d  = ms_valid_q;
    buf_valid_d = buf_valid_q;
    bus_d       = bus_q;
    rdata_buf_d = rdata_buf_q;
    first_d     = ms_allowin && es_to_ms_valid;
    if (ms_allowin) begin
      ms_valid_d  = es_to_ms_valid;
      bus_d       = es_to_ms_bus;
      buf_valid_d = 1'b0;
    end else if (first_q && ms_valid_q && load_op && !ws_allowin) begin
      // SRAM data is only valid in the first cycle; keep it while writeback stalls
      rdata_buf_d = data_sram_rdata;
      buf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      buf_valid_q <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      ms_valid_q  <= ms_valid_d;
      buf_valid_q <= buf_valid_d;
      first_q     <= first_d;
    end
  end

  always_ff @(posedge clk) begin
    bus_q       <= bus_d;
    rdata_buf_q <= rdata_buf_d;
  end

  assign rdata_sel = buf_valid_q ? rdata_buf_q : data_sram_rdata;

`ifdef MS_LOAD_EXT_EN
  logic [1:0] mem_size;
  logic       mem_unsigned;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  assign mem_size     = bus_q[74:73];
  assign mem_unsigned = bus_q[72];

  always_comb begin
    load_byte = 8'h00;
    load_half = 16'h0000;
    load_data = rdata_sel;
    case (alu_result[1:0])
      2'd0:    load_byte = rdata_sel[7:0];
      2'd1:    load_byte = rdata_sel[15:8];
      2'd2:    load_byte = rdata_sel[23:16];
      default: load_byte = rdata_sel[31:24];
    endcase
    load_half = alu_result[1] ? rdata_sel[31:16] : rdata_sel[15:0];
    case (mem_size)
      2'd0:    load_data = {{24{!mem_unsigned && load_byte[7]}}, load_byte};
      2'd1:    load_data = {{16{!mem_unsigned && load_half[15]}}, load_half};
      default: load_data = rdata_sel;
    endcase
  end
`else
  assign load_data = rdata_sel;
`endif

  assign final_result = load_op ? load_data : alu_result;

  assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
  assign ms_fwd_bus   = {ms_valid_q && gr_we, ms_valid_q && load_op, dest, final_result};

endmodule
